yiquan_attack_sprite_fetch: RTL
===============================

Name: yiquan_attack_sprite_fetch

Overview:
- Address-generation and pixel-qualify stage directly upstream of the yiquan attack-left sprite ROM.
- Inputs: the VGA beam position (DrawX/DrawY) and the character's top-left position.
- Computes the 19-bit ROM read address for the current animation frame.
- Realigns the in-sprite flag to the ROM's 1-cycle registered read.
- Emits the palette index plus a pixel_on flag to the colour mapper.
- Sequences the 4-frame attack animation, paced by frame_clk.

Parameters:
- SPRITE_W, 20, sprite width in pixels.
- SPRITE_H, 30, sprite height in pixels. One frame is 600 words; 4 frames = 2400 words.
- NUM_FRAMES, 4, number of animation frames, stacked contiguously in the ROM.
- FRAME_HOLD, 6, frame_clk ticks each frame is displayed (must be ≥1).
- TRANSPARENT_IDX, 5'h00, palette index treated as see-through.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  vsync-rate clock/level; sampled in the Clk domain.
- DrawX  in  10  current beam x.
- DrawY  in  10  current beam y.
- PosX  in  10  sprite top-left x.
- PosY  in  10  sprite top-left y.
- attack_start  in  1  single-cycle request to play the attack.
- rom_data  in  5  palette index from the sprite ROM; valid 1 Clk after rom_address.
- rom_address  out  19  ROM read address.
- pixel_on  out  1  current (delayed) pixel belongs to the sprite and is opaque.
- pixel_index  out  5  palette index to the colour mapper.
- attack_busy  out  1  high while the animation plays.
- attack_done  out  1  1-cycle pulse when the last frame finishes.

Behaviour:
- Clock/reset: one clock (Clk); reset is synchronous and active-high. On Reset all registers clear:
  - state=IDLE, frame=0, hold_cnt=0, edge-sync flops=0, in_box_d1=0.
  - Outputs: pixel_on=0, pixel_index=0, attack_busy=0, attack_done=0, rom_address=0.
- Tick detect: frame_clk passes through a 2-flop synchroniser, then a rising-edge detector. tick is high for exactly one Clk per frame_clk rising edge.
- FSM states IDLE, ATTACK, DONE:
  - IDLE: frame=0 (rest pose). attack_start=1 → ATTACK with frame=0, hold_cnt=0. A tick in the same cycle as attack_start is not counted.
  - ATTACK: attack_busy=1. On each tick:
    - if hold_cnt==FRAME_HOLD-1, set hold_cnt=0 and frame++;
    - else hold_cnt++.
    - On the tick where frame==NUM_FRAMES-1 and hold_cnt==FRAME_HOLD-1 → DONE, frame stays NUM_FRAMES-1.
    - attack_start is ignored in ATTACK.
  - DONE: one cycle with attack_done=1, attack_busy=0, then IDLE with frame=0. attack_start in DONE is ignored.
- Reset in any state: IDLE next cycle; no attack_done pulse.
- Address path (combinational from inputs and the frame register):
  - dx=DrawX-PosX and dy=DrawY-PosY, computed 11-bit signed.
  - in_box = (DrawX≥PosX) & (DrawX<PosX+SPRITE_W) & (DrawY≥PosY) & (DrawY<PosY+SPRITE_H). Sums are evaluated at 11 bits, so there is no wrap near x=1023.
  - If in_box: rom_address = frame*SPRITE_W*SPRITE_H + dy*SPRITE_W + dx, zero-extended to 19 bits. Otherwise rom_address=0.
- Pixel path:
  - in_box_d1 registers in_box, aligning with the ROM's registered output.
  - pixel_index = in_box_d1 ? rom_data : 0.
  - pixel_on = in_box_d1 & (rom_data != TRANSPARENT_IDX).
  - Latency DrawX/DrawY → pixel_on/pixel_index is exactly 1 Clk.
- Position changes take effect on the next beam sample; nothing is latched per frame.

Optional Feature:
- Macro: YIQUAN_SPRITE_MIRROR_EN.
- When defined: adds input port facing_right (1 bit). With facing_right=1, the column term becomes (SPRITE_W-1-dx), so one left-facing ROM serves both directions. facing_right is sampled combinationally with DrawX.
- When undefined: the port is absent and the column term is always dx.

Decomposition:
- Package yiquan_sprite_pkg holds:
  - SPRITE_W, SPRITE_H, NUM_FRAMES, FRAME_WORDS (=W*H), TRANSPARENT_IDX;
  - typedef enum logic [1:0] {IDLE, ATTACK, DONE} attack_state_t.
- Sub-module frame_tick_sync: 2-flop synchroniser plus rising-edge pulse. It is reused by the other character animators.

Test Plan:
- Reset → pixel_on=0, rom_address=0, attack_busy=0 for all DrawX/DrawY. Hold Reset mid-ATTACK (frame=2) → IDLE/frame 0 next cycle, no attack_done.
- IDLE, PosX=100, PosY=200, DrawX=105, DrawY=203 → rom_address=65. Next cycle with rom_data=7: pixel_on=1, pixel_index=7. With rom_data=0: pixel_on=0, pixel_index=0.
- Box edges at PosX=100, PosY=200:
  - DrawX=99 → rom_address=0, pixel_on=0 next cycle.
  - DrawX=119, DrawY=229 → rom_address=599.
  - DrawX=120 → out of box.
- Animation: pulse attack_start, then 24 frame_clk edges → frame advances 0→1→2→3 every 6 ticks. DrawX=PosX, DrawY=PosY gives rom_address 0, 600, 1200, 1800. attack_done pulses for exactly 1 cycle after tick 24, then IDLE.
- Simultaneous/ignored events:
  - attack_start coincident with a tick in IDLE → hold_cnt=0 after entry.
  - attack_start at ticks 3 and 10 during ATTACK → no restart; done still occurs after tick 24.
- YIQUAN_SPRITE_MIRROR_EN defined, facing_right=1, PosX=100, PosY=200, DrawX=100, DrawY=200 → rom_address=19. With facing_right=0 → rom_address=0.

Source files
------------

// File: rtl/yiquan_sprite_pkg.sv
// Shared constants and types for the yiquan sprite fetch path.
// Sprite geometry, frame count, transparent palette index and attack FSM states.
package yiquan_sprite_pkg;

   localparam int SPRITE_W    = 20;
   localparam int SPRITE_H    = 30;
   localparam int NUM_FRAMES  = 4;
   localparam int FRAME_HOLD  = 6;
   localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;

   localparam logic [4:0] TRANSPARENT_IDX = 5'h00;

   typedef enum logic [1:0] {
      IDLE,
      ATTACK,
      DONE
   } attack_state_t;

endpackage

// File: rtl/frame_tick_sync.sv
// Two-flop synchroniser for a slow frame clock plus rising-edge pulse.
// Ports: clk, reset (sync, active-high), sig_in (async level), tick (1-cycle pulse).
module frame_tick_sync (
   input  logic clk,
   input  logic reset,
   input  logic sig_in,
   output logic tick
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   always_comb begin
      sync1_d = sig_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/yiquan_attack_sprite_fetch.sv
// Address generation and pixel qualify for the yiquan attack-left sprite ROM.
// Ports: Clk, Reset (sync, active-high), frame_clk, DrawX/DrawY, PosX/PosY,
//   attack_start, rom_data in; rom_address, pixel_on, pixel_index,
//   attack_busy, attack_done out. `YIQUAN_SPRITE_MIRROR_EN adds facing_right.
module yiquan_attack_sprite_fetch
   import yiquan_sprite_pkg::*;
#(
   parameter int HOLD = FRAME_HOLD
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [9:0]  PosX,
   input  logic [9:0]  PosY,
   input  logic        attack_start,
`ifdef YIQUAN_SPRITE_MIRROR_EN
   input  logic        facing_right,
`endif
   input  logic [4:0]  rom_data,
   output logic [18:0] rom_address,
   output logic        pixel_on,
   output logic [4:0]  pixel_index,
   output logic        attack_busy,
   output logic        attack_done
);

   localparam int FR_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

   localparam logic [FR_W-1:0]   LAST_FRAME = FR_W'(NUM_FRAMES - 1);
   localparam logic [HOLD_W-1:0] LAST_HOLD  = HOLD_W'(HOLD - 1);

   attack_state_t     state_q, state_d;
   logic [FR_W-1:0]   frame_q, frame_d;
   logic [HOLD_W-1:0] hold_q,  hold_d;
   logic              in_box_d1_q, in_box_d1_d;

   logic tick;

   frame_tick_sync u_tick (
      .clk    (Clk),
      .reset  (Reset),
      .sig_in (frame_clk),
      .tick   (tick)
   );

   // Attack sequencer; a tick coincident with attack_start in IDLE is
   // dropped because IDLE forces hold to zero on entry.
   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            frame_d = '0;
            hold_d  = '0;
            if (attack_start) state_d = ATTACK;
         end
         ATTACK: begin
            if (tick) begin
               if (hold_q == LAST_HOLD) begin
                  hold_d = '0;
                  if (frame_q == LAST_FRAME) state_d = DONE;
                  else frame_d = frame_q + 1'b1;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            frame_d = '0;
            hold_d  = '0;
         end
         default: begin
            state_d = IDLE;
            frame_d = '0;
            hold_d  = '0;
         end
      endcase
   end

   // Beam-relative offsets at 11 bits so PosX+SPRITE_W never wraps.
   logic        [10:0] x_ext, y_ext, px_ext, py_ext;
   logic signed [10:0] dx, dy;
   logic               in_box;
   logic        [18:0] col_w, row_w, base_w, addr_w;

   always_comb begin
      x_ext  = {1'b0, DrawX};
      y_ext  = {1'b0, DrawY};
      px_ext = {1'b0, PosX};
      py_ext = {1'b0, PosY};
      dx     = x_ext - px_ext;
      dy     = y_ext - py_ext;
      in_box = (x_ext >= px_ext) & (x_ext < px_ext + 11'(SPRITE_W))
             & (y_ext >= py_ext) & (y_ext < py_ext + 11'(SPRITE_H));
      col_w  = {8'd0, dx};
`ifdef YIQUAN_SPRITE_MIRROR_EN
      // One left-facing ROM serves both directions by reversing columns.
      if (facing_right) col_w = 19'(SPRITE_W - 1) - {8'd0, dx};
`endif
      row_w  = {8'd0, dy} * 19'(SPRITE_W);
      base_w = 19'(frame_q) * 19'(FRAME_WORDS);
      addr_w = base_w + row_w + col_w;
      in_box_d1_d = in_box;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         frame_q     <= '0;
         hold_q      <= '0;
         in_box_d1_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         hold_q      <= hold_d;
         in_box_d1_q <= in_box_d1_d;
      end
   end

   assign rom_address = (in_box & ~Reset) ? addr_w : '0;
   assign pixel_on    = in_box_d1_q & (rom_data != TRANSPARENT_IDX);
   assign pixel_index = in_box_d1_q ? rom_data : 5'd0;
   assign attack_busy = (state_q == ATTACK);
   assign attack_done = (state_q == DONE);

endmodule
